// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle controller.
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 2
);
    logic [3:0]           Cond;
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic [3:0]           ALUFlags;
    logic                 PCWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/cond_unit.sv
// Architectural NZCV flags and condition-field evaluation.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_w,
    output logic       o_cond_ex
);
    logic [3:0] r_nzcv;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_nzcv;

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = 1'b0;
        endcase
    end

    // FlagW is only nonzero during EXEC, so the flags only move in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nzcv <= 4'b0000;
        end else if (o_cond_ex) begin
            if (i_flag_w[1]) r_nzcv[3:2] <= i_alu_flags[3:2];
            if (i_flag_w[0]) r_nzcv[1:0] <= i_alu_flags[1:0];
        end
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing, ALU decode and condition-gated writes.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter int EXT_ALU   = 0,
    parameter int ALUCTRL_W = 2
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_controller_if.slave bus
);
    state_t               r_state, w_next;
    logic                 w_next_pc, w_branch, w_regw, w_memw, w_alu_op, w_irwrite, w_adr_src;
    logic [1:0]           w_res_src, w_srca, w_srcb, w_flag_w;
    logic [ALUCTRL_W-1:0] w_alu_ctrl;
    logic                 w_nowrite, w_logic, w_unlisted, w_cond_ex;
    logic                 r_nowrite;

    generate
        if ((EXT_ALU != 0) ? (ALUCTRL_W != 3) : (ALUCTRL_W != 2)) begin : g_param_check
            $error("multicycle_controller: ALUCTRL_W must be 3 when EXT_ALU=1, else 2");
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b00:   w_next = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   w_next = MEMADR;
                    2'b10:   w_next = BRANCH;
                    default: w_next = FETCH;
                endcase
            end
            MEMADR:       w_next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:        w_next = MEMWB;
            EXECR, EXECI: w_next = ALUWB;
            default:      w_next = FETCH;
        endcase
    end

    always_comb begin
        w_next_pc = 1'b0;
        w_branch  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_alu_op  = 1'b0;
        w_irwrite = 1'b0;
        w_adr_src = 1'b0;
        w_res_src = RES_ALUOUT;
        w_srca    = SRCA_RD1;
        w_srcb    = SRCB_REG;
        case (r_state)
            FETCH: begin
                w_next_pc = 1'b1;
                w_irwrite = 1'b1;
                w_srca    = SRCA_PC;
                w_srcb    = SRCB_FOUR;
                w_res_src = RES_ALURESULT;
            end
            DECODE: begin
                w_srca    = SRCA_PC;
                w_srcb    = SRCB_FOUR;
                w_res_src = RES_ALURESULT;
            end
            MEMADR: w_srcb = SRCB_IMM;
            MEMRD:  w_adr_src = 1'b1;
            MEMWB: begin
                w_res_src = RES_DATA;
                w_regw    = 1'b1;
            end
            MEMWR: begin
                w_adr_src = 1'b1;
                w_memw    = 1'b1;
            end
            EXECR: w_alu_op = 1'b1;
            EXECI: begin
                w_srcb   = SRCB_IMM;
                w_alu_op = 1'b1;
            end
            ALUWB: w_regw = 1'b1;
            BRANCH: begin
                w_srca    = SRCA_ALUOUT;
                w_srcb    = SRCB_IMM;
                w_res_src = RES_ALURESULT;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_alu_ctrl = ALUCTRL_W'(ALU_ADD);
        w_nowrite  = 1'b0;
        w_logic    = 1'b0;
        w_unlisted = 1'b0;
        w_flag_w   = 2'b00;
        if (w_alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: w_alu_ctrl = ALUCTRL_W'(ALU_ADD);
                4'b0010: w_alu_ctrl = ALUCTRL_W'(ALU_SUB);
                4'b0000: begin w_alu_ctrl = ALUCTRL_W'(ALU_AND); w_logic = 1'b1; end
                4'b1100: begin w_alu_ctrl = ALUCTRL_W'(ALU_ORR); w_logic = 1'b1; end
                4'b0001: begin
                    if (EXT_ALU != 0) begin
                        w_alu_ctrl = ALUCTRL_W'(ALU_EOR);
                        w_logic    = 1'b1;
                    end else begin
                        w_unlisted = 1'b1;
                    end
                end
                4'b1010: begin
                    if (EXT_ALU != 0) begin
                        w_alu_ctrl = ALUCTRL_W'(ALU_SUB);
                        w_nowrite  = 1'b1;
                    end else begin
                        w_unlisted = 1'b1;
                    end
                end
                default: w_unlisted = 1'b1;
            endcase
            if (w_unlisted) w_nowrite = 1'b1;
            // Logical ops leave C and V alone.
            if (bus.Funct[0] && !w_unlisted) w_flag_w = w_logic ? 2'b10 : 2'b11;
        end
    end

    // ALUWB always directly follows EXEC, so a one-cycle capture is enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_nowrite <= 1'b0;
        else       r_nowrite <= w_alu_op & w_nowrite;
    end

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .i_cond      (bus.Cond),
        .i_alu_flags (bus.ALUFlags),
        .i_flag_w    (w_flag_w),
        .o_cond_ex   (w_cond_ex)
    );

    assign bus.PCWrite    = w_next_pc | (w_cond_ex & (w_branch | (w_regw & (bus.Rd == 4'hF))));
    assign bus.RegWrite   = w_regw & w_cond_ex & ~r_nowrite;
    assign bus.MemWrite   = w_memw & w_cond_ex;
    assign bus.IRWrite    = w_irwrite;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_res_src;
    assign bus.ALUSrcA    = w_srca;
    assign bus.ALUSrcB    = w_srcb;
    assign bus.ALUControl = w_alu_ctrl;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
endmodule
